reg_file_mp: RTL and testbench
==============================

# reg_file_mp

- Parametrised multi-read, dual-write register file with write-through bypass, a per-entry pending scoreboard and a sequenced bulk-clear engine.
- Sits in the decode stage of the 5-stage pipeline:
  - Port A takes ALU writeback; port B takes load/late writeback.
  - The scoreboard exposes in-flight destinations to hazard logic.
  - The clear engine wipes state on a software/debug flush without asserting global reset.

## Interface
Parameters:
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NRD, 2, number of read ports
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/sets

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- rd_addr  in  NRD*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NRD  pending bit of addressed entry after bypass, combinational
- wa_en / wa_addr / wa_data  in  1 / ADDR_W / DATA_W  write port A
- wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  write port B (priority)
- sb_set_en / sb_set_addr  in  1 / ADDR_W  mark destination pending at issue
- clr_req  in  1  start bulk clear (level, sampled in IDLE only)
- clr_busy  out  1  registered; high while clear engine active

## Operation
- Reset (rst_n low at an edge):
  - All DEPTH entries = 0; all pending bits = 0.
  - FSM = IDLE, clear counter = 0, clr_busy = 0.
  - Completes in one cycle; overrides every other input.
- Writes (IDLE only):
  - Each enabled port writes its entry at the edge.
  - wa_addr == wb_addr with both enabled: port B data is stored.
  - When ZERO_REG = 1, writes to address 0 are dropped.
- Scoreboard (IDLE only):
  - Enabled write on either port clears the pending bit of its address.
  - sb_set_en sets the pending bit of sb_set_addr.
  - Set and clear to the same address in one cycle: set wins.
  - When ZERO_REG = 1, address 0 is never pending.
- Read port i, in priority order:
  - ZERO_REG = 1 and addr 0 -> data 0, busy 0.
  - Else wb_en and wb_addr match -> wb_data, busy 0.
  - Else wa_en and wa_addr match -> wa_data, busy 0.
  - Else stored entry and its pending bit.
  - Bypass is active only in IDLE; in CLEAR, reads return stored entry and pending bit.
- Clear FSM, states IDLE and CLEAR:
  - IDLE and clr_req = 1 at an edge -> CLEAR, cnt = 0.
  - In CLEAR, each edge writes 0 to entry cnt, clears pending[cnt], cnt += 1.
  - At the edge where cnt = DEPTH-1 -> IDLE, cnt = 0.
  - In CLEAR, wa/wb/sb_set are ignored (dropped, not queued); clr_req is ignored.
  - clr_req held high through the return to IDLE starts a new clear on the next edge.
- Arithmetic: cnt is ADDR_W bits; the terminal check is explicit, so no reliance on wrap.

## Timing
- Read data and rd_busy: zero-cycle combinational from rd_addr, write ports and state.
- Write to read-back from the array: next cycle. Same cycle is served by bypass.
- clr_req sampled at edge t:
  - clr_busy is high from after edge t through edge t+DEPTH.
  - Entries 0..DEPTH-1 are cleared at edges t+1..t+DEPTH.
  - clr_busy is low after edge t+DEPTH; the first write is accepted at edge t+DEPTH+1.
  - Total: DEPTH busy cycles.
- Reset mid-clear: the next edge with rst_n low returns to IDLE with full reset state; the clear is not resumed.
- No combinational path from clr_req to any output.

## Test plan
- Reset, then write wa_addr = 3, data 0xDEADBEEF; next cycle read port 0 addr 3 -> 0xDEADBEEF.
- Read addr 0 with ZERO_REG = 1 -> 0, busy 0.
- Bypass/priority:
  - wa and wb both write addr 7 (0x1111 / 0x2222) while port 1 reads 7 -> 0x2222 same cycle.
  - Next cycle, array read of addr 7 -> 0x2222.
- Scoreboard:
  - sb_set addr 5 -> rd_busy = 1 the next cycle.
  - wa write to 5 -> busy 0 in that same cycle (bypass), stored bit 0 after the edge.
  - Simultaneous sb_set and write to addr 9 -> pending 1.
- Clear:
  - Fill all 32 entries with nonzero data and pending bits, pulse clr_req.
  - clr_busy is high for exactly 32 cycles; a wa write issued during the clear is dropped.
  - Afterwards all reads are 0 and all busy bits are 0.
- Reset mid-clear: assert rst_n = 0 at the 10th clear cycle -> clr_busy 0 next cycle, all entries 0. Parameter sweep: DATA_W = 64, ADDR_W = 3, NRD = 4 repeats the bypass and clear tests (clear = 8 cycles).

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with write-through bypass, pending scoreboard and bulk-clear engine.
// Reads are combinational and writes land at the next edge; while clr_busy is high, writes and sets are dropped, not held.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    wa_en,
  input  logic [ADDR_W-1:0]       wa_addr,
  input  logic [DATA_W-1:0]       wa_data,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    sb_set_en,
  input  logic [ADDR_W-1:0]       sb_set_addr,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pend, pend_nxt;
  logic                idle, wa_we, wb_we;

  assign idle     = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign wa_we    = idle && wa_en && !(ZERO_REG != 0 && wa_addr == '0);
  assign wb_we    = idle && wb_en && !(ZERO_REG != 0 && wb_addr == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Set is applied after the write-clears so a same-address set wins.
  always_comb begin
    pend_nxt = pend;
    if (state == CLEAR) begin
      pend_nxt[cnt] = 1'b0;
    end else begin
      if (wa_en)     pend_nxt[wa_addr]     = 1'b0;
      if (wb_en)     pend_nxt[wb_addr]     = 1'b0;
      if (sb_set_en) pend_nxt[sb_set_addr] = 1'b1;
    end
    if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  // Port B is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      if (wa_we) mem[wa_addr] <= wa_data;
      if (wb_we) mem[wb_addr] <= wb_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      d = mem[a];
      b = pend[a];
      if (ZERO_REG != 0 && a == '0) begin
        d = '0;
        b = 1'b0;
      end else if (idle && wb_en && wb_addr == a) begin
        d = wb_data;
        b = 1'b0;
      end else if (idle && wa_en && wa_addr == a) begin
        d = wa_data;
        b = 1'b0;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = d;
    assign rd_busy[g]                  = b;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default config plus a 64-bit / 8-entry / 4-read-port config.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [9:0]   rd_addr1;
  logic [63:0]  rd_data1;
  logic [1:0]   rd_busy1;
  logic         wa_en1, wb_en1, sb_set_en1, clr_req1, clr_busy1;
  logic [4:0]   wa_addr1, wb_addr1, sb_set_addr1;
  logic [31:0]  wa_data1, wb_data1;

  logic [11:0]  rd_addr2;
  logic [255:0] rd_data2;
  logic [3:0]   rd_busy2;
  logic         wa_en2, wb_en2, sb_set_en2, clr_req2, clr_busy2;
  logic [2:0]   wa_addr2, wb_addr2, sb_set_addr2;
  logic [63:0]  wa_data2, wb_data2;

  reg_file_mp dut1 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wa_en(wa_en1), .wa_addr(wa_addr1), .wa_data(wa_data1),
    .wb_en(wb_en1), .wb_addr(wb_addr1), .wb_data(wb_data1),
    .sb_set_en(sb_set_en1), .sb_set_addr(sb_set_addr1),
    .clr_req(clr_req1), .clr_busy(clr_busy1)
  );

  reg_file_mp #(.DATA_W(64), .ADDR_W(3), .NRD(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
    .wa_en(wa_en2), .wa_addr(wa_addr2), .wa_data(wa_data2),
    .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2),
    .sb_set_en(sb_set_en2), .sb_set_addr(sb_set_addr2),
    .clr_req(clr_req2), .clr_busy(clr_busy2)
  );

  typedef struct packed {
    logic        dut2;
    logic        kind;   // 0: read port data/busy, 1: clr_busy
    logic [1:0]  port;
    logic [63:0] data;
    logic        busy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_cycles = 0;
  logic  test_done = 1'b0;

  exp_t        m_e;
  string       m_nm;
  logic [63:0] act_d;
  logic        act_b;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      if (m_e.kind) begin
        act_d = 64'h0;
        act_b = m_e.dut2 ? clr_busy2 : clr_busy1;
      end else if (m_e.dut2) begin
        act_d = rd_data2[m_e.port*64 +: 64];
        act_b = rd_busy2[m_e.port];
      end else begin
        act_d = {32'h0, rd_data1[m_e.port*32 +: 32]};
        act_b = rd_busy1[m_e.port];
      end
      n_checks++;
      if (act_d !== m_e.data || act_b !== m_e.busy) begin
        n_fail++;
        $display("FAIL %s: got data=%h busy=%b, want data=%h busy=%b",
                 m_nm, act_d, act_b, m_e.data, m_e.busy);
      end
    end
  end

  always @(posedge clk) begin
    n_cycles++;
    if (n_cycles > 5000 && !test_done) begin
      n_fail++;
      $display("FAIL timeout: test did not complete within %0d cycles", n_cycles);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wa_en1 = 0; wb_en1 = 0; sb_set_en1 = 0; clr_req1 = 0;
    wa_en2 = 0; wb_en2 = 0; sb_set_en2 = 0; clr_req2 = 0;
  endtask

  task automatic push(input logic d2, input logic k, input int p,
                      input logic [63:0] d, input logic b, input string nm);
    exp_t e;
    e.dut2 = d2; e.kind = k; e.port = 2'(p); e.data = d; e.busy = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk1(input int p, input logic [4:0] a, input logic [63:0] d,
                      input logic b, input string nm);
    rd_addr1[p*5 +: 5] = a;
    push(1'b0, 1'b0, p, d, b, nm);
  endtask

  task automatic chk2(input int p, input logic [2:0] a, input logic [63:0] d,
                      input logic b, input string nm);
    rd_addr2[p*3 +: 3] = a;
    push(1'b1, 1'b0, p, d, b, nm);
  endtask

  task automatic exp_clr(input logic d2, input logic b, input string nm);
    push(d2, 1'b1, 0, 64'h0, b, nm);
  endtask

  task automatic fill1();
    for (int i = 1; i < 32; i++) begin
      wa_en1 = 1; wa_addr1 = 5'(i); wa_data1 = 32'h1000 + 32'(i);
      sb_set_en1 = 1; sb_set_addr1 = 5'(i);
      tick();
    end
    quiet();
  endtask

  initial begin
    rst_n = 0;
    quiet();
    rd_addr1 = '0; rd_addr2 = '0;
    wa_addr1 = '0; wb_addr1 = '0; sb_set_addr1 = '0; wa_data1 = '0; wb_data1 = '0;
    wa_addr2 = '0; wb_addr2 = '0; sb_set_addr2 = '0; wa_data2 = '0; wb_data2 = '0;
    tick(); tick();
    rst_n = 1;

    rd_addr1 = {5'd31, 5'd3};
    #1;
    n_checks++;
    if (clr_busy1 !== 1'b0 || clr_busy2 !== 1'b0 || rd_busy1 !== 2'b00 ||
        rd_data1[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_direct: clr_busy1=%b clr_busy2=%b rd_busy1=%b rd_data1=%h",
               clr_busy1, clr_busy2, rd_busy1, rd_data1);
    end

    chk1(0, 5'd3, 64'h0, 0, "rst_rd3");
    chk1(1, 5'd31, 64'h0, 0, "rst_rd31");
    exp_clr(0, 0, "rst_clr_busy");
    chk2(0, 3'd5, 64'h0, 0, "rst2_rd5");
    exp_clr(1, 0, "rst2_clr_busy");
    tick();

    wa_en1 = 1; wa_addr1 = 5'd3; wa_data1 = 32'hDEADBEEF;
    chk1(0, 5'd3, 64'hDEADBEEF, 0, "byp_wa3");
    tick(); quiet();
    chk1(0, 5'd3, 64'hDEADBEEF, 0, "arr_rd3");
    wa_en1 = 1; wa_addr1 = 5'd0; wa_data1 = 32'h1234;
    chk1(1, 5'd0, 64'h0, 0, "zero_rd0");
    tick(); quiet();

    wa_en1 = 1; wa_addr1 = 5'd7; wa_data1 = 32'h1111;
    wb_en1 = 1; wb_addr1 = 5'd7; wb_data1 = 32'h2222;
    chk1(1, 5'd7, 64'h2222, 0, "prio_byp7");
    tick(); quiet();
    chk1(1, 5'd7, 64'h2222, 0, "prio_arr7");
    tick();

    sb_set_en1 = 1; sb_set_addr1 = 5'd5;
    chk1(0, 5'd5, 64'h0, 0, "sb_pre5");
    tick(); quiet();
    chk1(0, 5'd5, 64'h0, 1, "sb_set5");
    tick();
    wa_en1 = 1; wa_addr1 = 5'd5; wa_data1 = 32'h55;
    chk1(0, 5'd5, 64'h55, 0, "sb_byp5");
    tick(); quiet();
    chk1(0, 5'd5, 64'h55, 0, "sb_clr5");
    tick();
    sb_set_en1 = 1; sb_set_addr1 = 5'd9;
    wb_en1 = 1; wb_addr1 = 5'd9; wb_data1 = 32'h99;
    chk1(1, 5'd9, 64'h99, 0, "sb_win9_byp");
    tick(); quiet();
    chk1(1, 5'd9, 64'h99, 1, "sb_win9");
    tick();

    fill1();
    chk1(0, 5'd20, 64'h1014, 1, "fill20");
    chk1(1, 5'd1, 64'h1001, 1, "fill1");
    clr_req1 = 1;
    exp_clr(0, 0, "clr_idle");
    tick(); quiet();
    for (int k = 0; k < 32; k++) begin
      exp_clr(0, 1, $sformatf("clr_busy_k%0d", k));
      if (k == 10) begin
        wa_en1 = 1; wa_addr1 = 5'd2; wa_data1 = 32'hBAD;
        wb_en1 = 1; wb_addr1 = 5'd31; wb_data1 = 32'hBEEF;
        chk1(0, 5'd31, 64'h101F, 1, "clr_nobyp31");
        chk1(1, 5'd2, 64'h0, 0, "clr_done2");
      end
      tick(); quiet();
    end
    exp_clr(0, 0, "clr_end");
    wa_en1 = 1; wa_addr1 = 5'd4; wa_data1 = 32'h44;
    chk1(1, 5'd4, 64'h44, 0, "post_clr_byp4");
    tick(); quiet();
    for (int i = 0; i < 32; i += 2) begin
      chk1(0, 5'(i), (i == 4) ? 64'h44 : 64'h0, 0, $sformatf("clr_rd%0d", i));
      chk1(1, 5'(i + 1), 64'h0, 0, $sformatf("clr_rd%0d", i + 1));
      tick();
    end

    fill1();
    clr_req1 = 1;
    tick(); quiet();
    for (int k = 0; k < 9; k++) tick();
    exp_clr(0, 1, "rstclr_busy9");
    chk1(0, 5'd20, 64'h1014, 1, "rstclr_pre20");
    rst_n = 0;
    tick();
    rst_n = 1;
    exp_clr(0, 0, "rstclr_idle");
    for (int i = 0; i < 32; i += 2) begin
      chk1(0, 5'(i), 64'h0, 0, $sformatf("rstclr_rd%0d", i));
      chk1(1, 5'(i + 1), 64'h0, 0, $sformatf("rstclr_rd%0d", i + 1));
      tick();
    end

    wa_en2 = 1; wa_addr2 = 3'd7; wa_data2 = 64'h1111_1111_0000_1111;
    wb_en2 = 1; wb_addr2 = 3'd7; wb_data2 = 64'h2222_2222_0000_2222;
    chk2(3, 3'd7, 64'h2222_2222_0000_2222, 0, "p2_prio_byp");
    chk2(0, 3'd6, 64'h0, 0, "p2_rd6");
    tick(); quiet();
    chk2(2, 3'd7, 64'h2222_2222_0000_2222, 0, "p2_prio_arr");
    tick();
    for (int i = 1; i < 8; i++) begin
      wa_en2 = 1; wa_addr2 = 3'(i); wa_data2 = 64'hA5A5_0000_0000_0000 | 64'(i);
      sb_set_en2 = 1; sb_set_addr2 = 3'(i);
      tick();
    end
    quiet();
    chk2(1, 3'd3, 64'hA5A5_0000_0000_0003, 1, "p2_fill3");
    clr_req2 = 1;
    exp_clr(1, 0, "p2_clr_idle");
    tick(); quiet();
    for (int k = 0; k < 8; k++) begin
      exp_clr(1, 1, $sformatf("p2_clr_busy_k%0d", k));
      tick();
    end
    exp_clr(1, 0, "p2_clr_end");
    for (int j = 0; j < 2; j++) begin
      for (int p = 0; p < 4; p++)
        chk2(p, 3'(j*4 + p), 64'h0, 0, $sformatf("p2_clr_rd%0d", j*4 + p));
      tick();
    end

    tick();
    test_done = 1'b1;
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL check_count: only %0d checks evaluated", n_checks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
